// File: rtl/data_mem.sv
// Data-memory responder for the RISC-V core's data port: word RAM with same-cycle reads
// plus a small register window (TOHOST/halt, CYCLE, STORE_CNT, STATUS).
module data_mem #(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        halt_o,
   output logic [31:0] tohost_o,
   output logic        err_o
);

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   localparam logic [1:0] OFS_TOHOST = 2'd0;
   localparam logic [1:0] OFS_CYCLE  = 2'd1;
   localparam logic [1:0] OFS_STORE  = 2'd2;
   localparam logic [1:0] OFS_STATUS = 2'd3;

   state_t                  state_r;
   state_t                  state_s;
   logic [31:0]             mem_r [0:(2**ADDR_WIDTH)-1];
   logic [31:0]             tohost_r;
   logic [31:0]             cycle_r;
   logic [31:0]             store_cnt_r;
   logic                    err_r;

   logic                    ram_sel_s;
   logic                    mmio_sel_s;
   logic                    unmap_sel_s;
   logic                    misalign_s;
   logic                    run_s;
   logic                    wr_s;
   logic                    wr_ram_s;
   logic                    wr_tohost_s;
   logic                    wr_cycle_s;
   logic                    wr_store_s;
   logic                    wr_status_s;
   logic                    err_set_s;
   logic                    err_clr_s;
   logic [ADDR_WIDTH-1:0]   word_idx_s;

   function automatic logic [31:0] sat_inc(input logic [31:0] value);
      if (value == 32'hFFFF_FFFF) begin
         sat_inc = value;
      end else begin
         sat_inc = value + 32'd1;
      end
   endfunction

   // Address decode; the byte offset bits never take part in selection
   assign ram_sel_s   = (addr[31:ADDR_WIDTH+2] == {(30-ADDR_WIDTH){1'b0}});
   assign mmio_sel_s  = (addr[31:4] == MMIO_BASE[31:4]);
   assign unmap_sel_s = !ram_sel_s && !mmio_sel_s;
   assign misalign_s  = (addr[1:0] != 2'b00);
   assign word_idx_s  = addr[ADDR_WIDTH+1:2];
   assign run_s       = (state_r == RUN);

   assign wr_s        = ce && we && run_s;
   assign wr_ram_s    = wr_s && ram_sel_s;
   assign wr_tohost_s = wr_s && mmio_sel_s && (addr[3:2] == OFS_TOHOST);
   assign wr_cycle_s  = wr_s && mmio_sel_s && (addr[3:2] == OFS_CYCLE);
   assign wr_store_s  = wr_s && mmio_sel_s && (addr[3:2] == OFS_STORE);
   assign wr_status_s = wr_s && mmio_sel_s && (addr[3:2] == OFS_STATUS);

   // Writes while halted leave err alone; reads can still flag errors
   assign err_set_s   = ce && (misalign_s || unmap_sel_s) && (!we || run_s);
   assign err_clr_s   = wr_status_s && wdata[1];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= RUN;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: HALTED is left only through reset
   always_comb begin
      state_s = state_r;
      case (state_r)
         RUN: begin
            if (wr_tohost_s) begin
               state_s = HALTED;
            end else begin
               state_s = RUN;
            end
         end
         HALTED:  state_s = HALTED;
         default: state_s = RUN;
      endcase
   end

   // FSM outputs
   always_comb begin
      halt_o = (state_r == HALTED);
   end

   // RAM storage: not reset, but a write is aborted while rst is held
   always_ff @(posedge clk) begin
      if (wr_ram_s && !rst) begin
         mem_r[word_idx_s] <= wdata;
      end
   end

   // Register window state and counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tohost_r    <= 32'd0;
         cycle_r     <= 32'd0;
         store_cnt_r <= 32'd0;
         err_r       <= 1'b0;
      end else begin
         if (wr_tohost_s) begin
            tohost_r <= wdata;
         end
         if (wr_cycle_s) begin
            cycle_r <= wdata;
         end else if (run_s) begin
            cycle_r <= cycle_r + 32'd1;
         end
         if (wr_store_s) begin
            store_cnt_r <= wdata;
         end else if (wr_ram_s) begin
            store_cnt_r <= sat_inc(store_cnt_r);
         end
         if (err_set_s) begin
            err_r <= 1'b1;
         end else if (err_clr_s) begin
            err_r <= 1'b0;
         end
      end
   end

   assign tohost_o = tohost_r;
   assign err_o    = err_r;

   // Same-cycle read mux; zero unless this is a read
   always_comb begin
      rdata = 32'd0;
      if (ce && !we) begin
         if (ram_sel_s) begin
            rdata = mem_r[word_idx_s];
         end else if (mmio_sel_s) begin
            case (addr[3:2])
               OFS_TOHOST: rdata = tohost_r;
               OFS_CYCLE:  rdata = cycle_r;
               OFS_STORE:  rdata = store_cnt_r;
               OFS_STATUS: rdata = {30'd0, err_r, halt_o};
               default:    rdata = 32'd0;
            endcase
         end else begin
            rdata = 32'd0;
         end
      end else begin
         rdata = 32'd0;
      end
   end

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem: RAM, register window, halt, saturation and reset.
module tb_data_mem;

   localparam logic [31:0] MB = 32'hFFFF_FF00;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        ce    = 1'b0;
   logic        we    = 1'b0;
   logic [31:0] addr  = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic [31:0] rdata;
   logic        halt_o;
   logic [31:0] tohost_o;
   logic        err_o;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] rv;

   data_mem #(.ADDR_WIDTH(10), .MMIO_BASE(MB)) dut (
      .clk      (clk),
      .rst      (rst),
      .ce       (ce),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .halt_o   (halt_o),
      .tohost_o (tohost_o),
      .err_o    (err_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      ce = 1'b0;
      we = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      ce    = 1'b1;
      we    = 1'b1;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      ce = 1'b0;
      we = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      ce   = 1'b1;
      we   = 1'b0;
      addr = a;
      #1;
      d = rdata;
      @(posedge clk);
      #1;
      ce = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_halt", {31'd0, halt_o}, 32'd0);
      check_eq("rst_tohost", tohost_o, 32'd0);
      check_eq("rst_err", {31'd0, err_o}, 32'd0);
      check_eq("rst_rdata", rdata, 32'd0);
      rst = 1'b0;

      // cycle counter and wrap
      idle(5);
      rd(MB + 32'h4, rv);   check_eq("cycle_5", rv, 32'd5);
      wr(MB + 32'h4, 32'hFFFF_FFFF);
      idle(1);
      rd(MB + 32'h4, rv);   check_eq("cycle_wrap", rv, 32'd0);

      // RAM write/read and store counter
      wr(32'h0, 32'h0BAD_F00D);
      wr(32'h10, 32'h1234_5678);
      rd(32'h10, rv);       check_eq("ram_rd10", rv, 32'h1234_5678);
      rd(MB + 32'h8, rv);   check_eq("store_cnt2", rv, 32'd2);

      // error flag: unmapped, status, clear, misaligned, priority
      check_eq("err_clean", {31'd0, err_o}, 32'd0);
      rd(32'h0001_0000, rv); check_eq("unmap_rdata", rv, 32'd0);
      check_eq("unmap_err", {31'd0, err_o}, 32'd1);
      rd(MB + 32'hC, rv);   check_eq("status_err", rv, 32'd2);
      wr(MB + 32'hC, 32'h2); check_eq("err_clr", {31'd0, err_o}, 32'd0);
      rd(32'h3, rv);        check_eq("misal_rdata", rv, 32'h0BAD_F00D);
      check_eq("misal_err", {31'd0, err_o}, 32'd1);
      wr(MB + 32'hD, 32'h2); check_eq("err_prio", {31'd0, err_o}, 32'd1);
      wr(MB + 32'hC, 32'h2); check_eq("err_clr2", {31'd0, err_o}, 32'd0);
      wr(32'h16, 32'h600D_CAFE);
      check_eq("misal_wr_err", {31'd0, err_o}, 32'd1);
      rd(32'h14, rv);       check_eq("misal_wr_data", rv, 32'h600D_CAFE);
      rd(MB + 32'h8, rv);   check_eq("store_cnt3", rv, 32'd3);
      wr(MB + 32'hC, 32'h2);

      // store counter saturation
      wr(MB + 32'h8, 32'hFFFF_FFFE);
      wr(32'h30, 32'h1);
      wr(32'h34, 32'h2);
      rd(MB + 32'h8, rv);   check_eq("store_sat", rv, 32'hFFFF_FFFF);
      wr(MB + 32'h8, 32'd7);

      // halt via TOHOST
      wr(32'h20, 32'h1111_1111);
      wr(MB + 32'h4, 32'd100);
      check_eq("pre_halt", {31'd0, halt_o}, 32'd0);
      wr(MB + 32'h0, 32'hDEAD_BEEF);
      check_eq("halt", {31'd0, halt_o}, 32'd1);
      check_eq("tohost", tohost_o, 32'hDEAD_BEEF);
      rd(MB + 32'h4, rv);   check_eq("cycle_frz1", rv, 32'd101);
      wr(32'h20, 32'h55);
      rd(32'h20, rv);       check_eq("halt_drop", rv, 32'h1111_1111);
      rd(MB + 32'h8, rv);   check_eq("halt_store", rv, 32'd8);
      wr(MB + 32'h0, 32'h0);
      check_eq("tohost_hold", tohost_o, 32'hDEAD_BEEF);
      wr(32'h0001_0000, 32'h0);
      check_eq("halt_err", {31'd0, err_o}, 32'd0);
      rd(MB + 32'h0, rv);   check_eq("tohost_rd", rv, 32'hDEAD_BEEF);
      rd(MB + 32'hC, rv);   check_eq("status_halt", rv, 32'd1);
      rd(MB + 32'h4, rv);   check_eq("cycle_frz2", rv, 32'd101);

      // asynchronous reset mid-cycle
      #2 rst = 1'b1;
      #1;
      check_eq("arst_halt", {31'd0, halt_o}, 32'd0);
      check_eq("arst_tohost", tohost_o, 32'd0);
      ce = 1'b1; we = 1'b0; addr = MB + 32'h4;
      #1 check_eq("arst_cycle", rdata, 32'd0);
      addr = 32'h20;
      #1 check_eq("arst_ram", rdata, 32'h1111_1111);
      ce = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // reset held across an edge aborts the pending store
      wr(32'h40, 32'hA5A5_A5A5);
      rd(32'h41, rv);       check_eq("a5_misal", rv, 32'hA5A5_A5A5);
      check_eq("a5_err", {31'd0, err_o}, 32'd1);
      ce = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h0;
      #2 rst = 1'b1;
      #1;
      check_eq("arst_err", {31'd0, err_o}, 32'd0);
      check_eq("wr_rdata0", rdata, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ce = 1'b0;
      we = 1'b0;
      rd(32'h40, rv);       check_eq("ram_survive", rv, 32'hA5A5_A5A5);
      rd(MB + 32'h8, rv);   check_eq("arst_store", rv, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
